// File: rtl/wb_pkg.sv
// Shared types and helpers for the writeback queue.
//   WB_XLEN / WB_RW : data and register-address widths of a queue entry
//   wb_entry_t      : one pending writeback (valid, destination, data)
//   sext_word()     : sign-extends the low 32 bits of a result to WB_XLEN
package wb_pkg;

    localparam int unsigned WB_XLEN = 64;
    localparam int unsigned WB_RW   = 5;

    typedef struct packed {
        logic               valid;
        logic [WB_RW-1:0]   rd;
        logic [WB_XLEN-1:0] data;
    } wb_entry_t;

    function automatic logic [WB_XLEN-1:0] sext_word(input logic [WB_XLEN-1:0] value);
        return {{(WB_XLEN - 32){value[31]}}, value[31:0]};
    endfunction

endpackage

// File: rtl/wb_fwd_lookup.sv
// Combinational forwarding search over the pending writeback entries.
// Scans from the youngest slot (tail-1) backwards; the first valid entry whose
// destination matches rs wins. Slots outside the live window have valid=0, so
// the scan needs no occupancy input.
//   entries : registered queue storage
//   tail    : next write slot (youngest entry lives at tail-1)
//   rs      : register being looked up; x0 never hits
//   hit     : a pending entry writes rs
//   data    : data of the youngest matching entry, zero on a miss
module wb_fwd_lookup
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  wb_entry_t                  entries [DEPTH],
    input  logic [$clog2(DEPTH)-1:0]   tail,
    input  logic [WB_RW-1:0]           rs,
    output logic                       hit,
    output logic [WB_XLEN-1:0]         data
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [PW-1:0] idx;

    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int i = 0; i < DEPTH; i++) begin
            idx = tail - PW'(i + 1);
            if (!hit && (rs != '0) && entries[idx].valid && (entries[idx].rd == rs)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/wb_queue.sv
// In-order writeback queue between the base integer EU and the register file.
// Buffers up to DEPTH results, sign-extends W-op results on entry, drains one
// entry per cycle to the RF write port and offers a combinational forwarding
// lookup over all pending entries.
//   clk, rst_n                        : clock, asynchronous active-low reset
//   eu_valid/eu_ready/eu_rd/eu_word/eu_result : EU result handshake
//   rf_we/rf_ready/rf_waddr/rf_wdata  : RF write port (head of queue)
//   fwd_rs/fwd_hit/fwd_data           : forwarding lookup for stage 2
//   count                             : current occupancy
// Entry widths come from wb_pkg; XLEN and RW must match WB_XLEN and WB_RW.
module wb_queue
    import wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = WB_XLEN,
    parameter int unsigned RW    = WB_RW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     eu_valid,
    output logic                     eu_ready,
    input  logic [RW-1:0]            eu_rd,
    input  logic                     eu_word,
    input  logic [XLEN-1:0]          eu_result,
    output logic                     rf_we,
    input  logic                     rf_ready,
    output logic [RW-1:0]            rf_waddr,
    output logic [XLEN-1:0]          rf_wdata,
    input  logic [RW-1:0]            fwd_rs,
    output logic                     fwd_hit,
    output logic [XLEN-1:0]          fwd_data,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    wb_entry_t       entries_q [DEPTH];
    logic [PW-1:0]   head_q, tail_q;
    logic [CW-1:0]   count_q, count_d;
    logic            accept, push, pop;
    logic [XLEN-1:0] store_data;
    wb_entry_t       head_entry;

    // Readiness depends only on occupancy: no pass-through when full.
    assign eu_ready = (count_q < FULL_CNT);
    assign accept   = eu_valid && eu_ready;
    // Writes to x0 are consumed but never occupy a slot.
    assign push     = accept && (eu_rd != '0);
    assign pop      = rf_we && rf_ready;

    assign store_data = eu_word ? sext_word(eu_result) : eu_result;

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // Push and pop never target the same slot: that needs count==0 (no pop)
    // or count==DEPTH (no push).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                entries_q[i] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            if (pop) begin
                entries_q[head_q].valid <= 1'b0;
                head_q                  <= head_q + PW'(1);
            end
            if (push) begin
                entries_q[tail_q] <= '{valid: 1'b1, rd: eu_rd, data: store_data};
                tail_q            <= tail_q + PW'(1);
            end
            count_q <= count_d;
        end
    end

    assign head_entry = entries_q[head_q];
    assign rf_we      = (count_q != '0);
    assign rf_waddr   = rf_we ? head_entry.rd : '0;
    assign rf_wdata   = rf_we ? head_entry.data : '0;
    assign count      = count_q;

    wb_fwd_lookup #(
        .DEPTH (DEPTH)
    ) u_fwd_lookup (
        .entries (entries_q),
        .tail    (tail_q),
        .rs      (fwd_rs),
        .hit     (fwd_hit),
        .data    (fwd_data)
    );

endmodule

// File: tb/tb_wb_queue.sv
module tb_wb_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        eu_valid;
    logic        eu_ready;
    logic [4:0]  eu_rd;
    logic        eu_word;
    logic [63:0] eu_result;
    logic        rf_we;
    logic        rf_ready;
    logic [4:0]  rf_waddr;
    logic [63:0] rf_wdata;
    logic [4:0]  fwd_rs;
    logic        fwd_hit;
    logic [63:0] fwd_data;
    logic [2:0]  count;

    typedef struct {
        logic [4:0]  rd;
        logic [63:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_pass  = 0;
    int   n_total = 0;

    always #5 clk = ~clk;

    wb_queue #(
        .DEPTH (4),
        .XLEN  (64),
        .RW    (5)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .eu_valid  (eu_valid),
        .eu_ready  (eu_ready),
        .eu_rd     (eu_rd),
        .eu_word   (eu_word),
        .eu_result (eu_result),
        .rf_we     (rf_we),
        .rf_ready  (rf_ready),
        .rf_waddr  (rf_waddr),
        .rf_wdata  (rf_wdata),
        .fwd_rs    (fwd_rs),
        .fwd_hit   (fwd_hit),
        .fwd_data  (fwd_data),
        .count     (count)
    );

    function automatic logic [63:0] ref_sext(input logic [63:0] v);
        return {{32{v[31]}}, v[31:0]};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    // Inputs change 1 time unit after the rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [4:0] rd, input logic w, input logic [63:0] r);
        exp_t e;
        eu_valid  = 1'b1;
        eu_rd     = rd;
        eu_word   = w;
        eu_result = r;
        if (rd != 5'd0) begin
            e.rd   = rd;
            e.data = w ? ref_sext(r) : r;
            sb.push_back(e);
        end
    endtask

    task automatic idle();
        eu_valid  = 1'b0;
        eu_rd     = 5'd0;
        eu_word   = 1'b0;
        eu_result = 64'd0;
    endtask

    // A write commits at the next rising edge when rf_we && rf_ready is seen here.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && rf_we === 1'b1 && rf_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_write", {59'd0, rf_waddr}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                e = sb.pop_front();
                chk("wb_addr", {59'd0, rf_waddr}, {59'd0, e.rd});
                chk("wb_data", rf_wdata, e.data);
            end
        end
    end

    initial begin
        rst_n    = 1'b0;
        rf_ready = 1'b0;
        fwd_rs   = 5'd0;
        idle();
        #12;
        chk("rst_rf_we", {63'd0, rf_we}, 64'd0);
        chk("rst_waddr", {59'd0, rf_waddr}, 64'd0);
        chk("rst_wdata", rf_wdata, 64'd0);
        chk("rst_fwd_hit", {63'd0, fwd_hit}, 64'd0);
        chk("rst_fwd_data", fwd_data, 64'd0);
        chk("rst_eu_ready", {63'd0, eu_ready}, 64'd1);
        chk("rst_count", {61'd0, count}, 64'd0);
        step();
        rst_n = 1'b1;
        step();

        // Single result, plain op
        rf_ready = 1'b1;
        send(5'd5, 1'b0, 64'h1234);
        step();
        idle();
        chk("lat_rf_we", {63'd0, rf_we}, 64'd1);
        chk("lat_waddr", {59'd0, rf_waddr}, 64'd5);
        chk("lat_wdata", rf_wdata, 64'h1234);
        chk("lat_count", {61'd0, count}, 64'd1);
        step();
        chk("drained_count", {61'd0, count}, 64'd0);
        chk("empty_rf_we", {63'd0, rf_we}, 64'd0);
        step();
        chk("empty_ready_noop", {61'd0, count}, 64'd0);

        // W-op sign extension, back to back
        send(5'd3, 1'b1, 64'hFFFF_FFFF_8000_0001);
        step();
        chk("w_neg_data", rf_wdata, 64'hFFFF_FFFF_8000_0001);
        send(5'd3, 1'b1, 64'h0000_0000_8000_0001);
        step();
        chk("w_upper0_data", rf_wdata, 64'hFFFF_FFFF_8000_0001);
        send(5'd3, 1'b1, 64'hDEAD_BEEF_7FFF_FFFF);
        step();
        chk("w_pos_data", rf_wdata, 64'h0000_0000_7FFF_FFFF);
        idle();
        step();
        step();

        // Fill to full with RF stalled
        rf_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            send(5'(i), 1'b0, 64'h100 + 64'(i));
            step();
        end
        idle();
        chk("full_count", {61'd0, count}, 64'd4);
        chk("full_eu_ready", {63'd0, eu_ready}, 64'd0);
        chk("full_head_addr", {59'd0, rf_waddr}, 64'd1);
        step();
        chk("stall_head_hold", rf_wdata, 64'h101);
        rf_ready = 1'b1;
        step();
        chk("after_deq_ready", {63'd0, eu_ready}, 64'd1);
        chk("after_deq_count", {61'd0, count}, 64'd3);
        step();
        step();
        step();
        chk("full_drained", {61'd0, count}, 64'd0);

        // Forwarding: youngest match, same-cycle accept invisible, x0 handling
        rf_ready = 1'b0;
        send(5'd7, 1'b0, 64'hAAAA_0000_0000_000A);
        step();
        send(5'd7, 1'b0, 64'hBBBB_0000_0000_000B);
        fwd_rs = 5'd7;
        #1;
        chk("fwd_pre_accept", fwd_data, 64'hAAAA_0000_0000_000A);
        step();
        idle();
        chk("fwd_hit7", {63'd0, fwd_hit}, 64'd1);
        chk("fwd_youngest", fwd_data, 64'hBBBB_0000_0000_000B);
        fwd_rs = 5'd0;
        send(5'd0, 1'b0, 64'hDEAD);
        step();
        idle();
        chk("x0_count", {61'd0, count}, 64'd2);
        chk("x0_fwd_hit", {63'd0, fwd_hit}, 64'd0);
        chk("x0_fwd_data", fwd_data, 64'd0);
        fwd_rs = 5'd9;
        #1;
        chk("miss_fwd_hit", {63'd0, fwd_hit}, 64'd0);
        fwd_rs = 5'd7;
        rf_ready = 1'b1;
        #1;
        chk("fwd_during_deq", fwd_data, 64'hBBBB_0000_0000_000B);
        step();
        step();
        chk("fwd_drained_hit", {63'd0, fwd_hit}, 64'd0);
        fwd_rs = 5'd0;

        // Sustained accept + drain at occupancy 2, pointers wrap
        rf_ready = 1'b0;
        send(5'd20, 1'b0, 64'h2000);
        step();
        send(5'd21, 1'b0, 64'h2001);
        step();
        rf_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            send(5'(k + 10), 1'b0, 64'h3000 + 64'(k));
            step();
            chk("steady_count", {61'd0, count}, 64'd2);
        end
        idle();
        step();
        step();
        chk("steady_drained", {61'd0, count}, 64'd0);

        // Asynchronous reset with entries pending
        rf_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            send(5'(i + 12), 1'b0, 64'h4000 + 64'(i));
            step();
        end
        idle();
        chk("pre_rst_count", {61'd0, count}, 64'd3);
        fwd_rs = 5'd12;
        #2;
        rst_n = 1'b0;
        sb.delete();
        #1;
        chk("arst_rf_we", {63'd0, rf_we}, 64'd0);
        chk("arst_count", {61'd0, count}, 64'd0);
        chk("arst_fwd_hit", {63'd0, fwd_hit}, 64'd0);
        rf_ready = 1'b1;
        step();
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("post_rst_rf_we", {63'd0, rf_we}, 64'd0);
        end
        chk("sb_empty_end", 64'(sb.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
